master_cmd_dispatcher: RTL and testbench
========================================

// Module: master_cmd_dispatcher
// PURPOSE
//  Parametrised master command dispatcher for the ECT system. It takes 16-bit commands from the USB
//  receive path, decodes the low-byte opcode onto NUM_CH mutually exclusive enables, and handles a
//  frame-synchronised stop with a timeout. It also auto-clears calibration commands at frame end.
//  Each enable output may be a level or a one-cycle pulse, selected per channel.
// PARAMETERS
//  CMD_W       16        command word width (>=12)
//  OP_W        8         opcode field width, opcode = USBRcv[OP_W-1:0]
//  NUM_CH      5         number of enable channels; opcode k (1..NUM_CH) selects En[k-1]
//  STOP_OP     6         stop opcode; must be > NUM_CH
//  PULSE_MASK  5'b10000  bit i = 1: En[i] is a one-cycle pulse; bit i = 0: En[i] is a level
//  AUTO_TAG_A  4'h1      Cmd[CMD_W-1:CMD_W-4] tag that auto-clears on FrameEnd
//  AUTO_TAG_B  4'hE      second auto-clear tag
//  TMO_W       16        stop-timeout counter width
//  STOP_TMO    16'hFFFF  cycles allowed in STOP_WAIT before forced stop (must be >= 1)
// PORTS
//  Clk          in   1       system clock, rising edge
//  Rst          in   1       synchronous reset, active low
//  USBRReady    in   1       USB word-ready flag; its rising edge qualifies USBRcv
//  USBRcv       in   CMD_W   USB command word
//  FrameEnd     in   1       level: the current measurement frame is complete
//  En           out  NUM_CH  channel enables, at most one bit set (one-hot or zero)
//  Cmd          out  CMD_W   last accepted command (registered)
//  Stat         out  2       state: 00 IDLE, 01 DECODE, 10 STOP_WAIT
//  Busy         out  1       1 while Stat != IDLE
//  CmdErr       out  1       one-cycle pulse: invalid opcode, or command edge while Busy
//  StopTmo      out  1       one-cycle pulse: stop forced by timeout
//  TestLED      out  1       toggles on channel-0 start and on auto-clear
// BEHAVIOUR
//  Reset (Rst = 0 at a Clk edge): En = 0, Cmd = 0, Stat = IDLE, Busy = 0, CmdErr = 0, StopTmo = 0,
//   TestLED = 1, edge register = 0, timeout counter = 0. Reset overrides any operation in progress.
//  Edge detect: prevRdy <= USBRReady every cycle. A new word is present when prevRdy == 0 and USBRReady == 1.
//  IDLE, priority order:
//   1. Auto-clear: Cmd tag == AUTO_TAG_A/B and FrameEnd == 1 -> En <= 0, Cmd <= 0, toggle TestLED.
//      Any edge arriving in the same cycle is dropped (no CmdErr).
//   2. Edge, opcode in 1..NUM_CH or == STOP_OP -> Cmd <= USBRcv, Stat <= DECODE.
//   3. Edge, any other opcode -> CmdErr = 1 for one cycle; Cmd and state unchanged.
//   4. No edge -> clear pulse-type En bits (En & ~PULSE_MASK); hold everything else.
//  DECODE (exactly 1 cycle):
//   - Opcode k -> En <= one-hot(k-1), Stat <= IDLE. If k == 1, toggle TestLED.
//   - STOP_OP -> Stat <= STOP_WAIT, tmo <= 0.
//   - Latency: edge cycle T, Cmd valid at T+1, En valid at T+2.
//  STOP_WAIT:
//   - FrameEnd == 1 -> En <= 0, Stat <= IDLE.
//   - Otherwise, when tmo == STOP_TMO-1 -> En <= 0, StopTmo = 1 for one cycle, Stat <= IDLE.
//   - Otherwise tmo <= tmo + 1; En is held, so running channels finish the frame.
//   - If FrameEnd and timeout coincide, FrameEnd wins and StopTmo stays 0.
//  Edge while Busy: the word is ignored and CmdErr pulses. A level held high does not re-trigger.
//  An enable of a new channel replaces the previous one; the one-hot property holds every cycle.
// TESTING
//  T1 reset, then USBRcv = 16'h0002 edge -> Cmd = 0002 at T+1, En = 5'b00010 at T+2, Busy high for 1 cycle.
//  T2 16'h0005 (pulse channel) -> En[4] high exactly 1 cycle, then En = 0; Stat returns to 00.
//  T3 16'h1001 then FrameEnd = 1 -> En = 0, Cmd = 0, TestLED toggled twice (start + clear), back to original value.
//  T4 0003 running, then 0006 with FrameEnd held 0, STOP_TMO = 8 -> En[2] held 8 cycles, then StopTmo pulse and En = 0.
//  T5 0006 with FrameEnd asserted on the 3rd STOP_WAIT cycle -> En = 0, no StopTmo; opcode 8'h07 -> CmdErr pulse, Stat stays 00.
//  T6 Rst low during STOP_WAIT -> all outputs at reset values on the next edge; an edge during DECODE -> CmdErr, ignored.

Source files
------------

// File: rtl/master_cmd_dispatcher.sv
// rtl/master_cmd_dispatcher.sv - master command dispatcher: opcode decode, frame-synchronised stop, auto-clear
//
// Ports:
//   Clk        in   1       system clock, rising edge
//   Rst        in   1       synchronous reset, active low
//   USBRReady  in   1       USB word-ready flag; its rising edge qualifies USBRcv
//   USBRcv     in   CMD_W   USB command word
//   FrameEnd   in   1       level: current measurement frame is complete
//   En         out  NUM_CH  channel enables, one-hot or zero
//   Cmd        out  CMD_W   last accepted command
//   Stat       out  2       00 IDLE, 01 DECODE, 10 STOP_WAIT
//   Busy       out  1       high while Stat != IDLE
//   CmdErr     out  1       one-cycle pulse: invalid opcode or command edge while Busy
//   StopTmo    out  1       one-cycle pulse: stop forced by timeout
//   TestLED    out  1       toggles on channel-0 start and on auto-clear
module master_cmd_dispatcher #(
  parameter int                CMD_W      = 16,
  parameter int                OP_W       = 8,
  parameter int                NUM_CH     = 5,
  parameter int                STOP_OP    = 6,
  parameter logic [NUM_CH-1:0] PULSE_MASK = 5'b10000,
  parameter logic [3:0]        AUTO_TAG_A = 4'h1,
  parameter logic [3:0]        AUTO_TAG_B = 4'hE,
  parameter int                TMO_W      = 16,
  parameter logic [TMO_W-1:0]  STOP_TMO   = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              USBRReady,
  input  logic [CMD_W-1:0]  USBRcv,
  input  logic              FrameEnd,
  output logic [NUM_CH-1:0] En,
  output logic [CMD_W-1:0]  Cmd,
  output logic [1:0]        Stat,
  output logic              Busy,
  output logic              CmdErr,
  output logic              StopTmo,
  output logic              TestLED
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    DECODE    = 2'b01,
    STOP_WAIT = 2'b10
  } state_t;

  localparam logic [OP_W-1:0]  OP_STOP  = OP_W'(STOP_OP);
  localparam logic [OP_W-1:0]  OP_MAXCH = OP_W'(NUM_CH);
  localparam logic [OP_W-1:0]  OP_CH0   = OP_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = STOP_TMO - TMO_W'(1);

  state_t            state;
  state_t            stateNext;
  logic              prevRdy;
  logic [TMO_W-1:0]  tmo;
  logic [TMO_W-1:0]  tmoNext;
  logic [NUM_CH-1:0] enNext;
  logic [CMD_W-1:0]  cmdNext;
  logic              cmdErrNext;
  logic              stopTmoNext;
  logic              ledNext;

  logic              newWord;
  logic [OP_W-1:0]   rcvOp;
  logic [OP_W-1:0]   cmdOp;
  logic [3:0]        cmdTag;
  logic              rcvOpValid;
  logic              autoClear;
  logic [NUM_CH-1:0] cmdOneHot;

  assign newWord    = USBRReady & ~prevRdy;
  assign rcvOp      = USBRcv[OP_W-1:0];
  assign cmdOp      = Cmd[OP_W-1:0];
  assign cmdTag     = Cmd[CMD_W-1 -: 4];
  assign rcvOpValid = ((rcvOp != '0) && (rcvOp <= OP_MAXCH)) || (rcvOp == OP_STOP);
  assign autoClear  = FrameEnd && ((cmdTag == AUTO_TAG_A) || (cmdTag == AUTO_TAG_B));

  assign Stat = state;
  assign Busy = (state != IDLE);

  // Opcode k maps to En[k-1]; opcodes outside 1..NUM_CH give zero.
  always_comb begin
    cmdOneHot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmdOneHot[i] = (cmdOp == OP_W'(i + 1));
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= IDLE;
      prevRdy <= 1'b0;
      tmo     <= '0;
      En      <= '0;
      Cmd     <= '0;
      CmdErr  <= 1'b0;
      StopTmo <= 1'b0;
      TestLED <= 1'b1;
    end else begin
      state   <= stateNext;
      prevRdy <= USBRReady;
      tmo     <= tmoNext;
      En      <= enNext;
      Cmd     <= cmdNext;
      CmdErr  <= cmdErrNext;
      StopTmo <= stopTmoNext;
      TestLED <= ledNext;
    end
  end

  always_comb begin
    stateNext   = state;
    tmoNext     = tmo;
    enNext      = En;
    cmdNext     = Cmd;
    cmdErrNext  = 1'b0;
    stopTmoNext = 1'b0;
    ledNext     = TestLED;

    case (state)
      IDLE: begin
        // Pulse channels are only ever set on the DECODE->IDLE step, so
        // dropping them on every IDLE cycle makes them exactly one cycle wide.
        enNext = En & ~PULSE_MASK;
        if (autoClear) begin
          // A word arriving together with the auto-clear is dropped silently.
          enNext  = '0;
          cmdNext = '0;
          ledNext = ~TestLED;
        end else if (newWord) begin
          if (rcvOpValid) begin
            cmdNext   = USBRcv;
            stateNext = DECODE;
          end else begin
            cmdErrNext = 1'b1;
          end
        end
      end

      DECODE: begin
        cmdErrNext = newWord;
        if (cmdOp == OP_STOP) begin
          tmoNext   = '0;
          stateNext = STOP_WAIT;
        end else begin
          enNext    = cmdOneHot;
          stateNext = IDLE;
          if (cmdOp == OP_CH0) begin
            ledNext = ~TestLED;
          end
        end
      end

      STOP_WAIT: begin
        cmdErrNext = newWord;
        // FrameEnd is tested first so it wins over a coinciding timeout.
        if (FrameEnd) begin
          enNext    = '0;
          stateNext = IDLE;
        end else if (tmo == TMO_LAST) begin
          enNext      = '0;
          stopTmoNext = 1'b1;
          stateNext   = IDLE;
        end else begin
          tmoNext = tmo + TMO_W'(1);
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_master_cmd_dispatcher.sv
// tb/tb_master_cmd_dispatcher.sv - self-checking bench for master_cmd_dispatcher
module tb_master_cmd_dispatcher;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        USBRReady;
  logic [15:0] USBRcv;
  logic        FrameEnd;
  logic [4:0]  En;
  logic [15:0] Cmd;
  logic [1:0]  Stat;
  logic        Busy;
  logic        CmdErr;
  logic        StopTmo;
  logic        TestLED;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] word;
    logic [15:0] expCmd;
    logic [4:0]  expEnA;
    logic [4:0]  expEnB;
    logic        expErr;
    logic        expLed;
  } vec_t;

  vec_t vecs[10];
  vec_t sb[$];
  vec_t exp;

  always #5 Clk = ~Clk;

  master_cmd_dispatcher #(
    .STOP_TMO(16'd8)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .USBRReady(USBRReady),
    .USBRcv   (USBRcv),
    .FrameEnd (FrameEnd),
    .En       (En),
    .Cmd      (Cmd),
    .Stat     (Stat),
    .Busy     (Busy),
    .CmdErr   (CmdErr),
    .StopTmo  (StopTmo),
    .TestLED  (TestLED)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Raises USBRReady for one cycle; returns on the negedge after the edge cycle.
  task automatic sendWord(input logic [15:0] w);
    @(negedge Clk);
    USBRcv    = w;
    USBRReady = 1'b1;
    @(negedge Clk);
    USBRReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0002, 16'h0002, 5'b00010, 5'b00010, 1'b0, 1'b1};
    vecs[1] = '{16'h0005, 16'h0005, 5'b10000, 5'b00000, 1'b0, 1'b1};
    vecs[2] = '{16'h0001, 16'h0001, 5'b00001, 5'b00001, 1'b0, 1'b0};
    vecs[3] = '{16'h0007, 16'h0001, 5'b00001, 5'b00001, 1'b1, 1'b0};
    vecs[4] = '{16'h0004, 16'h0004, 5'b01000, 5'b01000, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0004, 5'b01000, 5'b01000, 1'b1, 1'b0};
    vecs[6] = '{16'h00FF, 16'h0004, 5'b01000, 5'b01000, 1'b1, 1'b0};
    vecs[7] = '{16'h0103, 16'h0103, 5'b00100, 5'b00100, 1'b0, 1'b0};
    vecs[8] = '{16'h0001, 16'h0001, 5'b00001, 5'b00001, 1'b0, 1'b1};
    vecs[9] = '{16'h0005, 16'h0005, 5'b10000, 5'b00000, 1'b0, 1'b1};

    Rst       = 1'b0;
    USBRReady = 1'b0;
    USBRcv    = 16'h0000;
    FrameEnd  = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_state", {En, Cmd, Stat, Busy, CmdErr, StopTmo, TestLED},
        {5'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
    Rst = 1'b1;

    // Level held high triggers once only.
    @(negedge Clk);
    USBRcv    = 16'h0002;
    USBRReady = 1'b1;
    @(negedge Clk);
    chk("lvl_stat_t1", Stat, 2'b01);
    chk("lvl_cmd_t1", Cmd, 16'h0002);
    chk("lvl_busy_t1", Busy, 1'b1);
    @(negedge Clk);
    chk("lvl_en_t2", En, 5'b00010);
    chk("lvl_stat_t2", Stat, 2'b00);
    @(negedge Clk);
    chk("lvl_noretrig", {CmdErr, Stat, Busy}, 4'b0000);
    USBRReady = 1'b0;

    // Table vectors through the scoreboard.
    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      sendWord(vecs[i].word);
      exp = sb.pop_front();
      chk($sformatf("v%0d_cmd", i), Cmd, exp.expCmd);
      chk($sformatf("v%0d_err", i), CmdErr, exp.expErr);
      chk($sformatf("v%0d_stat_t1", i), Stat, exp.expErr ? 2'b00 : 2'b01);
      chk($sformatf("v%0d_busy_t1", i), Busy, !exp.expErr);
      @(negedge Clk);
      chk($sformatf("v%0d_en_t2", i), En, exp.expEnA);
      chk($sformatf("v%0d_idle_t2", i), {Stat, CmdErr}, 3'b000);
      @(negedge Clk);
      chk($sformatf("v%0d_en_t3", i), En, exp.expEnB);
      chk($sformatf("v%0d_led", i), TestLED, exp.expLed);
    end

    // Auto-clear on tag 1: LED toggles on start and on clear.
    sendWord(16'h1001);
    chk("ac1_cmd", Cmd, 16'h1001);
    @(negedge Clk);
    chk("ac1_en", En, 5'b00001);
    chk("ac1_led_start", TestLED, 1'b0);
    FrameEnd = 1'b1;
    @(negedge Clk);
    chk("ac1_clear", {En, Cmd, Stat}, {5'b0, 16'h0, 2'b00});
    chk("ac1_led_clear", TestLED, 1'b1);
    FrameEnd = 1'b0;

    // Auto-clear on tag E drops a word arriving in the same cycle.
    sendWord(16'hE002);
    chk("ac2_cmd", Cmd, 16'hE002);
    @(negedge Clk);
    chk("ac2_en", En, 5'b00010);
    FrameEnd  = 1'b1;
    USBRcv    = 16'h0003;
    USBRReady = 1'b1;
    @(negedge Clk);
    chk("ac2_clear", {En, Cmd, Stat, CmdErr}, {5'b0, 16'h0, 2'b00, 1'b0});
    chk("ac2_led", TestLED, 1'b0);
    USBRReady = 1'b0;
    FrameEnd  = 1'b0;
    @(negedge Clk);
    chk("ac2_dropped", {Stat, CmdErr, Cmd}, {2'b00, 1'b0, 16'h0});

    // Stop with timeout, STOP_TMO = 8.
    sendWord(16'h0003);
    @(negedge Clk);
    chk("t4_run", En, 5'b00100);
    sendWord(16'h0006);
    chk("t4_decode", {Stat, Cmd}, {2'b01, 16'h0006});
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      chk($sformatf("t4_wait%0d", k), {Stat, En, StopTmo, Busy}, {2'b10, 5'b00100, 1'b0, 1'b1});
    end
    @(negedge Clk);
    chk("t4_timeout", {Stat, En, StopTmo}, {2'b00, 5'b00000, 1'b1});
    @(negedge Clk);
    chk("t4_tmo_pulse_end", StopTmo, 1'b0);

    // Stop ended by FrameEnd on the 3rd STOP_WAIT cycle.
    sendWord(16'h0003);
    @(negedge Clk);
    chk("t5_run", En, 5'b00100);
    sendWord(16'h0006);
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    chk("t5_wait3", {Stat, En}, {2'b10, 5'b00100});
    FrameEnd = 1'b1;
    @(negedge Clk);
    chk("t5_frame_stop", {Stat, En, StopTmo}, {2'b00, 5'b00000, 1'b0});
    FrameEnd = 1'b0;
    @(negedge Clk);
    chk("t5_no_tmo", StopTmo, 1'b0);
    sendWord(16'h0007);
    chk("t5_bad_op", {CmdErr, Stat, Cmd}, {1'b1, 2'b00, 16'h0006});

    // Edge while busy, then reset during STOP_WAIT.
    sendWord(16'h0003);
    @(negedge Clk);
    sendWord(16'h0006);
    @(negedge Clk);
    USBRcv    = 16'h0002;
    USBRReady = 1'b1;
    @(negedge Clk);
    chk("t6_busy_err", {CmdErr, Stat, Cmd, En}, {1'b1, 2'b10, 16'h0006, 5'b00100});
    USBRReady = 1'b0;
    Rst       = 1'b0;
    @(negedge Clk);
    chk("t6_reset", {En, Cmd, Stat, Busy, CmdErr, StopTmo, TestLED},
        {5'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
    Rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
